id_ex_stage: RTL

- ID/EX pipeline register for the 5-stage MIPS core. It sits directly upstream of the EX-stage forwarding unit and supplies the IDEX Rs/Rt addresses, operands and control bits that the forwarding unit and ALU muxes consume.
- Integrates load-use hazard detection. It stalls PC and IF/ID, and inserts a bubble into EX when the instruction in EX is a load whose destination feeds the instruction in ID.
- Also handles branch flush, external hold, and a saturating bubble counter for performance debug.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: control-word packing used by ID/EX, EX/MEM and MEM/WB.
// No logic; constants and a control-word struct only.
package pipe_pkg;

    localparam int CTRL_W = 8;

    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: EX holds a load whose destination is a source of the ID instruction.
// Latency: purely combinational.
// Backpressure: produces the stall itself; a flush in the same cycle masks it.
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_addr,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rt,
    input  logic       flush,
    output logic       stall
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_write_addr == id_rs_addr);
    assign rt_match = id_uses_rt && (ex_write_addr == id_rt_addr);

    // $0 is hardwired, so a load targeting it never produces a value worth waiting for.
    assign stall = !flush && ex_valid && ex_mem_read && (ex_write_addr != 5'd0)
                   && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and saturating bubble counter.
// Latency: one cycle from id_* to ex_*; a load-use hazard costs exactly one bubble.
// Backpressure: hold_i freezes every register; hazard_stall_o freezes PC and IF/ID upstream.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_rs_addr_i,
    input  logic [4:0]        id_rt_addr_i,
    input  logic [4:0]        id_rd_addr_i,
    input  logic              id_uses_rt_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [4:0]        ex_rs_addr_o,
    output logic [4:0]        ex_rt_addr_o,
    output logic [4:0]        ex_write_addr_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_valid_o,
    output logic              hazard_stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic [4:0] id_write_addr;

    assign id_write_addr = id_ctrl_i[CTRL_REG_DST] ? id_rd_addr_i : id_rt_addr_i;

    load_use_detect u_load_use_detect (
        .ex_valid      (ex_valid_o),
        .ex_mem_read   (ex_ctrl_o[CTRL_MEM_READ]),
        .ex_write_addr (ex_write_addr_o),
        .id_rs_addr    (id_rs_addr_i),
        .id_rt_addr    (id_rt_addr_i),
        .id_uses_rt    (id_uses_rt_i),
        .flush         (flush_i),
        .stall         (hazard_stall_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_pc_o         <= '0;
            ex_rs_data_o    <= '0;
            ex_rt_data_o    <= '0;
            ex_imm_o        <= '0;
            ex_rs_addr_o    <= '0;
            ex_rt_addr_o    <= '0;
            ex_write_addr_o <= '0;
            ex_ctrl_o       <= '0;
            ex_valid_o      <= 1'b0;
            bubble_cnt_o    <= '0;
        end else if (!hold_i) begin
            // Data fields load unconditionally; in a bubble they are simply ignored downstream.
            ex_pc_o      <= id_pc_i;
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            if (flush_i || hazard_stall_o) begin
                // Zeroed addresses keep the forwarding unit from matching on a bubble.
                ex_rs_addr_o    <= '0;
                ex_rt_addr_o    <= '0;
                ex_write_addr_o <= '0;
                ex_ctrl_o       <= '0;
                ex_valid_o      <= 1'b0;
                // hazard_stall_o is already masked by flush, so only load-use bubbles count.
                if (hazard_stall_o && (bubble_cnt_o != {CNT_W{1'b1}})) begin
                    bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
                end
            end else begin
                ex_rs_addr_o    <= id_rs_addr_i;
                ex_rt_addr_o    <= id_rt_addr_i;
                ex_write_addr_o <= id_write_addr;
                ex_ctrl_o       <= id_ctrl_i;
                ex_valid_o      <= 1'b1;
            end
        end
    end

endmodule
